// File: rtl/ads41_delay_cal_if.sv
// Bus between the ADS41 IDELAY calibration engine and its controller/front end.
// The slave modport is the calibration engine; the master modport drives start, samples and readback select.
interface ads41_delay_cal_if #(
   parameter int NBITS = 12
);
   localparam int NLANES = NBITS / 2;

   logic              start;
   logic [NBITS-1:0]  d_in;
   logic              d_valid;
   logic [31:0]       idelay_val;
   logic [15:0]       idelay_ctrl;
   logic              busy;
   logic              done;
   logic              fail;
   logic [NLANES-1:0] lane_fail;
   logic [3:0]        lane_sel;
   logic [4:0]        lane_tap;
   logic [5:0]        lane_width;

   modport master (
      output start, d_in, d_valid, lane_sel,
      input  idelay_val, idelay_ctrl, busy, done, fail, lane_fail, lane_tap, lane_width
   );

   modport slave (
      input  start, d_in, d_valid, lane_sel,
      output idelay_val, idelay_ctrl, busy, done, fail, lane_fail, lane_tap, lane_width
   );
endinterface

// File: rtl/ads41_delay_cal.sv
// Per-lane IDELAY calibration: sweeps every tap against the ADC toggle pattern,
// finds each DDR lane's widest error-free window and loads the window centre.
module ads41_delay_cal #(
   parameter int NBITS         = 12,
   parameter int NTAPS         = 32,
   parameter int SETTLE_CYCLES = 64,
   parameter int CHECK_SAMPLES = 256,
   parameter int MIN_EYE       = 4,
   parameter int DEFAULT_TAP   = 8
) (
   input logic             clk,
   input logic             rst_n,
   ads41_delay_cal_if.slave bus
);
   localparam int NLANES = NBITS / 2;
   localparam int SW     = $clog2(SETTLE_CYCLES + 1);
   localparam int CW     = $clog2(CHECK_SAMPLES + 1);
   localparam int LW     = (NLANES > 1) ? $clog2(NLANES) : 1;

   typedef enum logic [2:0] {IDLE, LOAD, SETTLE, CHECK, UPDATE, APPLY, FINISH} state_t;

   state_t            state;
   logic [4:0]        tap;
   logic [SW-1:0]     settle_cnt;
   logic [CW-1:0]     samp_cnt;
   logic [NBITS-1:0]  prev;
   logic [NLANES-1:0] err;
   logic [NLANES-1:0] lane_err;
   logic [5:0]        run_len    [NLANES];
   logic [4:0]        run_start  [NLANES];
   logic [5:0]        best_len   [NLANES];
   logic [4:0]        best_start [NLANES];
   logic [LW-1:0]     lane_idx;
   logic [4:0]        val_q;
   logic [NLANES-1:0] ctrl_q;
   logic              busy_q;
   logic              done_q;
   logic              fail_q;
   logic [NLANES-1:0] lane_fail_q;
   logic [4:0]        sel_tap;
   logic [5:0]        sel_width;

   // Eye centre rounds toward the start of the window for even widths.
   function automatic logic [4:0] center_tap(input logic [4:0] start, input logic [5:0] len);
      logic [5:0] half;
      if (len == 6'd0) return 5'(DEFAULT_TAP);
      half = (len - 6'd1) >> 1;
      return start + half[4:0];
   endfunction

   // A lane is good when both of its DDR bits inverted since the previous valid sample.
   always_comb begin
      lane_err = '0;
      for (int i = 0; i < NLANES; i++)
         lane_err[i] = (bus.d_in[2*i +: 2] != ~prev[2*i +: 2]);
   end

   always_comb begin
      sel_tap   = '0;
      sel_width = '0;
      for (int i = 0; i < NLANES; i++) begin
         if (bus.lane_sel == 4'(i)) begin
            sel_tap   = center_tap(best_start[i], best_len[i]);
            sel_width = best_len[i];
         end
      end
   end

   assign bus.idelay_val  = 32'(val_q);
   assign bus.idelay_ctrl = 16'(ctrl_q);
   assign bus.busy        = busy_q;
   assign bus.done        = done_q;
   assign bus.fail        = fail_q;
   assign bus.lane_fail   = lane_fail_q;
   assign bus.lane_tap    = sel_tap;
   assign bus.lane_width  = sel_width;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         tap         <= '0;
         settle_cnt  <= '0;
         samp_cnt    <= '0;
         prev        <= '0;
         err         <= '0;
         lane_idx    <= '0;
         val_q       <= '0;
         ctrl_q      <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         fail_q      <= 1'b0;
         lane_fail_q <= '0;
         for (int i = 0; i < NLANES; i++) begin
            run_len[i]    <= '0;
            run_start[i]  <= '0;
            best_len[i]   <= '0;
            best_start[i] <= '0;
         end
      end else begin
         ctrl_q <= '0;
         case (state)
            IDLE: begin
               if (bus.start) begin
                  tap         <= '0;
                  err         <= '0;
                  done_q      <= 1'b0;
                  fail_q      <= 1'b0;
                  lane_fail_q <= '0;
                  busy_q      <= 1'b1;
                  for (int i = 0; i < NLANES; i++) begin
                     run_len[i]    <= '0;
                     run_start[i]  <= '0;
                     best_len[i]   <= '0;
                     best_start[i] <= '0;
                  end
                  state <= LOAD;
               end
            end
            LOAD: begin
               val_q      <= tap;
               ctrl_q     <= '1;
               settle_cnt <= '0;
               state      <= SETTLE;
            end
            SETTLE: begin
               if (settle_cnt == SW'(SETTLE_CYCLES - 1)) begin
                  samp_cnt <= '0;
                  state    <= CHECK;
               end else begin
                  settle_cnt <= settle_cnt + SW'(1);
               end
            end
            CHECK: begin
               if (bus.d_valid) begin
                  prev <= bus.d_in;
                  // The first sample of each tap only seeds prev.
                  if (samp_cnt != '0) err <= err | lane_err;
                  if (samp_cnt == CW'(CHECK_SAMPLES - 1)) state <= UPDATE;
                  else samp_cnt <= samp_cnt + CW'(1);
               end
            end
            UPDATE: begin
               for (int i = 0; i < NLANES; i++) begin
                  if (!err[i]) begin
                     run_len[i] <= run_len[i] + 6'd1;
                     if (run_len[i] == 6'd0) run_start[i] <= tap;
                     // Strictly greater: on a tie the earlier window stays.
                     if (run_len[i] + 6'd1 > best_len[i]) begin
                        best_len[i]   <= run_len[i] + 6'd1;
                        best_start[i] <= (run_len[i] == 6'd0) ? tap : run_start[i];
                     end
                  end else begin
                     run_len[i] <= '0;
                  end
               end
               err <= '0;
               if (tap == 5'(NTAPS - 1)) begin
                  lane_idx <= '0;
                  state    <= APPLY;
               end else begin
                  tap   <= tap + 5'd1;
                  state <= LOAD;
               end
            end
            APPLY: begin
               val_q                 <= center_tap(best_start[lane_idx], best_len[lane_idx]);
               ctrl_q                <= NLANES'(1) << lane_idx;
               lane_fail_q[lane_idx] <= (best_len[lane_idx] < 6'(MIN_EYE));
               if (lane_idx == LW'(NLANES - 1)) state <= FINISH;
               else lane_idx <= lane_idx + LW'(1);
            end
            FINISH: begin
               busy_q <= 1'b0;
               done_q <= 1'b1;
               fail_q <= |lane_fail_q;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
